// File: rtl/pipeline_control_unit.sv
// Pipelined control decode for a single-issue core: combinational D-stage decode, E/M/W control registers.
// Optional macro BRANCH_EXT_EN: E-stage funct3 selects beq (000) / bne (001) branch condition.
module pipeline_control_unit #(
   parameter int ALUCTRL_W = 3,
   parameter int IMMSRC_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic [6:0]           funct7,
   input  logic                 flush_e,
   input  logic                 zero_e,
   output logic [IMMSRC_W-1:0]  ImmSrcD,
   output logic                 RegWriteE,
   output logic                 MemWriteE,
   output logic                 ALUSrcE,
   output logic                 BranchE,
   output logic                 JumpE,
   output logic [1:0]           ResultSrcE,
   output logic [ALUCTRL_W-1:0] ALUControlE,
   output logic                 PCSrcE,
   output logic                 RegWriteM,
   output logic                 MemWriteM,
   output logic [1:0]           ResultSrcM,
   output logic                 RegWriteW,
   output logic [1:0]           ResultSrcW,
   output logic                 IllegalW
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic       reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d, illegal_d;
   logic [1:0] imm_src_d, result_src_d, alu_op_d;
   logic [2:0] alu_ctrl_d;

   // Only funct7[5] distinguishes sub from add; the other bits carry no control meaning.
   logic unused_funct7;
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   always_comb begin
      reg_write_d  = 1'b0;
      imm_src_d    = 2'b00;
      alu_src_d    = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 2'b00;
      branch_d     = 1'b0;
      jump_d       = 1'b0;
      alu_op_d     = 2'b00;
      illegal_d    = 1'b0;
      case (op)
         OP_LW: begin
            reg_write_d  = 1'b1;
            alu_src_d    = 1'b1;
            result_src_d = 2'b01;
         end
         OP_SW: begin
            imm_src_d   = 2'b01;
            alu_src_d   = 1'b1;
            mem_write_d = 1'b1;
         end
         OP_R: begin
            reg_write_d = 1'b1;
            alu_op_d    = 2'b10;
         end
         OP_I: begin
            reg_write_d = 1'b1;
            alu_src_d   = 1'b1;
            alu_op_d    = 2'b10;
         end
         OP_BEQ: begin
            imm_src_d = 2'b10;
            branch_d  = 1'b1;
            alu_op_d  = 2'b01;
         end
         OP_JAL: begin
            reg_write_d  = 1'b1;
            imm_src_d    = 2'b11;
            result_src_d = 2'b10;
            jump_d       = 1'b1;
         end
         default: illegal_d = 1'b1;
      endcase
   end

   always_comb begin
      alu_ctrl_d = 3'b000;
      case (alu_op_d)
         2'b01: alu_ctrl_d = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  alu_ctrl_d = (op[5] & funct7[5]) ? 3'b001 : 3'b000;
               3'b010:  alu_ctrl_d = 3'b101;
               3'b110:  alu_ctrl_d = 3'b011;
               3'b111:  alu_ctrl_d = 3'b010;
               default: alu_ctrl_d = 3'b000;
            endcase
         end
         default: alu_ctrl_d = 3'b000;
      endcase
   end

   assign ImmSrcD = IMMSRC_W'(imm_src_d);

   logic                 reg_write_e_q, mem_write_e_q, alu_src_e_q, branch_e_q, jump_e_q, illegal_e_q;
   logic [1:0]           result_src_e_q;
   logic [ALUCTRL_W-1:0] alu_ctrl_e_q;
`ifdef BRANCH_EXT_EN
   logic [2:0]           funct3_e_q;
`endif

   // A flush loads an all-zero bubble so nothing downstream writes state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write_e_q  <= 1'b0;
         mem_write_e_q  <= 1'b0;
         alu_src_e_q    <= 1'b0;
         branch_e_q     <= 1'b0;
         jump_e_q       <= 1'b0;
         illegal_e_q    <= 1'b0;
         result_src_e_q <= 2'b00;
         alu_ctrl_e_q   <= '0;
`ifdef BRANCH_EXT_EN
         funct3_e_q     <= 3'b000;
`endif
      end else if (flush_e) begin
         reg_write_e_q  <= 1'b0;
         mem_write_e_q  <= 1'b0;
         alu_src_e_q    <= 1'b0;
         branch_e_q     <= 1'b0;
         jump_e_q       <= 1'b0;
         illegal_e_q    <= 1'b0;
         result_src_e_q <= 2'b00;
         alu_ctrl_e_q   <= '0;
`ifdef BRANCH_EXT_EN
         funct3_e_q     <= 3'b000;
`endif
      end else begin
         reg_write_e_q  <= reg_write_d;
         mem_write_e_q  <= mem_write_d;
         alu_src_e_q    <= alu_src_d;
         branch_e_q     <= branch_d;
         jump_e_q       <= jump_d;
         illegal_e_q    <= illegal_d;
         result_src_e_q <= result_src_d;
         alu_ctrl_e_q   <= ALUCTRL_W'(alu_ctrl_d);
`ifdef BRANCH_EXT_EN
         funct3_e_q     <= funct3;
`endif
      end
   end

   logic       reg_write_m_q, mem_write_m_q, illegal_m_q;
   logic [1:0] result_src_m_q;
   logic       reg_write_w_q, illegal_w_q;
   logic [1:0] result_src_w_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write_m_q  <= 1'b0;
         mem_write_m_q  <= 1'b0;
         illegal_m_q    <= 1'b0;
         result_src_m_q <= 2'b00;
         reg_write_w_q  <= 1'b0;
         illegal_w_q    <= 1'b0;
         result_src_w_q <= 2'b00;
      end else begin
         reg_write_m_q  <= reg_write_e_q;
         mem_write_m_q  <= mem_write_e_q;
         illegal_m_q    <= illegal_e_q;
         result_src_m_q <= result_src_e_q;
         reg_write_w_q  <= reg_write_m_q;
         illegal_w_q    <= illegal_m_q;
         result_src_w_q <= result_src_m_q;
      end
   end

   logic branch_cond;
`ifdef BRANCH_EXT_EN
   always_comb begin
      case (funct3_e_q)
         3'b000:  branch_cond = zero_e;
         3'b001:  branch_cond = ~zero_e;
         default: branch_cond = 1'b0;
      endcase
   end
`else
   assign branch_cond = zero_e;
`endif

   assign PCSrcE = (branch_e_q & branch_cond) | jump_e_q;

   assign RegWriteE   = reg_write_e_q;
   assign MemWriteE   = mem_write_e_q;
   assign ALUSrcE     = alu_src_e_q;
   assign BranchE     = branch_e_q;
   assign JumpE       = jump_e_q;
   assign ResultSrcE  = result_src_e_q;
   assign ALUControlE = alu_ctrl_e_q;
   assign RegWriteM   = reg_write_m_q;
   assign MemWriteM   = mem_write_m_q;
   assign ResultSrcM  = result_src_m_q;
   assign RegWriteW   = reg_write_w_q;
   assign ResultSrcW  = result_src_w_q;
   assign IllegalW    = illegal_w_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: directed scenarios then random instruction streams against a table-driven model.
module tb_pipeline_control_unit;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       flush_e, zero_e;
   logic [1:0] ImmSrcD;
   logic       RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
   logic [1:0] ResultSrcE;
   logic [2:0] ALUControlE;
   logic       PCSrcE, RegWriteM, MemWriteM;
   logic [1:0] ResultSrcM;
   logic       RegWriteW;
   logic [1:0] ResultSrcW;
   logic       IllegalW;

   pipeline_control_unit dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
      .flush_e(flush_e), .zero_e(zero_e), .ImmSrcD(ImmSrcD),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
      .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
      .ALUControlE(ALUControlE), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM),
      .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RegWriteW(RegWriteW),
      .ResultSrcW(ResultSrcW), .IllegalW(IllegalW)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rw, mw, asrc, br, jmp, ill;
      logic [1:0] rs, imm;
      logic [2:0] alu, f3;
   } ctl_t;

   ctl_t exp_e, exp_m, exp_w;
   int checks = 0;
   int errors = 0;

   function automatic ctl_t ref_decode(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
      ctl_t c;
      c = '0;
      c.f3 = f3;
      if (o == LW) begin
         c.rw = 1; c.asrc = 1; c.rs = 2'd1;
      end else if (o == SW) begin
         c.imm = 2'd1; c.asrc = 1; c.mw = 1;
      end else if (o == RT || o == IT) begin
         c.rw = 1; c.asrc = (o == IT);
         if (f3 == 3'd0)      c.alu = (o == RT && f7[5]) ? 3'd1 : 3'd0;
         else if (f3 == 3'd2) c.alu = 3'd5;
         else if (f3 == 3'd6) c.alu = 3'd3;
         else if (f3 == 3'd7) c.alu = 3'd2;
         else                 c.alu = 3'd0;
      end else if (o == BEQ) begin
         c.imm = 2'd2; c.br = 1; c.alu = 3'd1;
      end else if (o == JAL) begin
         c.rw = 1; c.imm = 2'd3; c.rs = 2'd2; c.jmp = 1;
      end else begin
         c.ill = 1;
      end
      return c;
   endfunction

   function automatic logic ref_pcsrc(input ctl_t e, input logic z);
      logic taken;
`ifdef BRANCH_EXT_EN
      taken = (e.f3 == 3'd0) ? z : ((e.f3 == 3'd1) ? !z : 1'b0);
`else
      taken = z;
`endif
      return e.jmp | (e.br & taken);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_regs();
      chk("RegWriteE",   32'(RegWriteE),   32'(exp_e.rw));
      chk("MemWriteE",   32'(MemWriteE),   32'(exp_e.mw));
      chk("ALUSrcE",     32'(ALUSrcE),     32'(exp_e.asrc));
      chk("BranchE",     32'(BranchE),     32'(exp_e.br));
      chk("JumpE",       32'(JumpE),       32'(exp_e.jmp));
      chk("ResultSrcE",  32'(ResultSrcE),  32'(exp_e.rs));
      chk("ALUControlE", 32'(ALUControlE), 32'(exp_e.alu));
      chk("RegWriteM",   32'(RegWriteM),   32'(exp_m.rw));
      chk("MemWriteM",   32'(MemWriteM),   32'(exp_m.mw));
      chk("ResultSrcM",  32'(ResultSrcM),  32'(exp_m.rs));
      chk("RegWriteW",   32'(RegWriteW),   32'(exp_w.rw));
      chk("ResultSrcW",  32'(ResultSrcW),  32'(exp_w.rs));
      chk("IllegalW",    32'(IllegalW),    32'(exp_w.ill));
   endtask

   task automatic step(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic fl, input logic z);
      ctl_t d;
      op = o; funct3 = f3; funct7 = f7; flush_e = fl; zero_e = z;
      #1;
      d = ref_decode(o, f3, f7);
      chk("ImmSrcD", 32'(ImmSrcD), 32'(d.imm));
      chk("PCSrcE",  32'(PCSrcE),  32'(ref_pcsrc(exp_e, z)));
      @(posedge clk);
      #1;
      exp_w = exp_m;
      exp_m = exp_e;
      exp_e = fl ? '0 : d;
      check_regs();
   endtask

   initial begin
      logic [6:0] ops [6] = '{LW, SW, RT, IT, BEQ, JAL};
      logic [6:0] ro, rf7;
      logic       bne_exp;

      rst = 1'b0; op = JAL; funct3 = 3'd0; funct7 = 7'd0; flush_e = 1'b0; zero_e = 1'b1;
      exp_e = '0; exp_m = '0; exp_w = '0;
      #2;
      check_regs();
      chk("reset_ImmSrcD_jal", 32'(ImmSrcD), 32'd3);
      chk("reset_PCSrcE", 32'(PCSrcE), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step(RT, 3'd0, 7'd0, 1'b0, 1'b0);
      chk("first_R_RegWriteE", 32'(RegWriteE), 32'd1);

      // lw, sw, R add flowing to W
      step(LW, 3'd2, 7'd0, 1'b0, 1'b0);
      step(SW, 3'd2, 7'd0, 1'b0, 1'b0);
      chk("seq_MemWriteM_lw", 32'(MemWriteM), 32'd0);
      step(RT, 3'd0, 7'd0, 1'b0, 1'b0);
      chk("seq_MemWriteM_sw", 32'(MemWriteM), 32'd1);
      chk("seq_RegWriteW_lw", 32'(RegWriteW), 32'd1);
      chk("seq_ResultSrcW_lw", 32'(ResultSrcW), 32'd1);
      step(IT, 3'd0, 7'd0, 1'b0, 1'b0);
      chk("seq_MemWriteM_R", 32'(MemWriteM), 32'd0);
      chk("seq_RegWriteW_sw", 32'(RegWriteW), 32'd0);
      chk("seq_ResultSrcW_sw", 32'(ResultSrcW), 32'd0);
      step(IT, 3'd0, 7'd0, 1'b0, 1'b0);
      chk("seq_RegWriteW_R", 32'(RegWriteW), 32'd1);
      chk("seq_ResultSrcW_R", 32'(ResultSrcW), 32'd0);

      // ALU decode for R-type with funct7=0100000
      step(RT, 3'd0, 7'h20, 1'b0, 1'b0);
      chk("alu_sub", 32'(ALUControlE), 32'd1);
      step(RT, 3'd7, 7'h20, 1'b0, 1'b0);
      chk("alu_and", 32'(ALUControlE), 32'd2);
      step(RT, 3'd2, 7'h20, 1'b0, 1'b0);
      chk("alu_slt", 32'(ALUControlE), 32'd5);
      step(IT, 3'd0, 7'h20, 1'b0, 1'b0);
      chk("alu_addi_f7", 32'(ALUControlE), 32'd0);

      // beq / jal
      step(BEQ, 3'd0, 7'd0, 1'b0, 1'b0);
      zero_e = 1'b1; #1;
      chk("beq_taken", 32'(PCSrcE), 32'd1);
      zero_e = 1'b0; #1;
      chk("beq_not_taken", 32'(PCSrcE), 32'd0);
      step(JAL, 3'd0, 7'd0, 1'b0, 1'b0);
      chk("jal_PCSrcE", 32'(PCSrcE), 32'd1);
      chk("jal_ResultSrcE", 32'(ResultSrcE), 32'd2);
      chk("jal_ImmSrcD", 32'(ImmSrcD), 32'd3);

      // flushed lw becomes a bubble through E, M, W
      step(LW, 3'd2, 7'd0, 1'b1, 1'b1);
      chk("bubble_RegWriteE", 32'(RegWriteE), 32'd0);
      chk("bubble_ResultSrcE", 32'(ResultSrcE), 32'd0);
      chk("bubble_PCSrcE", 32'(PCSrcE), 32'd0);
      step(SW, 3'd2, 7'd0, 1'b0, 1'b0);
      chk("bubble_RegWriteM", 32'(RegWriteM), 32'd0);
      chk("bubble_MemWriteM", 32'(MemWriteM), 32'd0);
      step(7'h7F, 3'd0, 7'd0, 1'b0, 1'b0);
      chk("bubble_RegWriteW", 32'(RegWriteW), 32'd0);
      chk("bubble_IllegalW", 32'(IllegalW), 32'd0);
      step(RT, 3'd0, 7'd0, 1'b0, 1'b0);
      step(RT, 3'd0, 7'd0, 1'b0, 1'b0);
      chk("illegal_IllegalW", 32'(IllegalW), 32'd1);
      chk("illegal_RegWriteW", 32'(RegWriteW), 32'd0);

      // bne-style funct3 with zero_e=0
      step(BEQ, 3'd1, 7'd0, 1'b0, 1'b0);
      zero_e = 1'b0; #1;
`ifdef BRANCH_EXT_EN
      bne_exp = 1'b1;
`else
      bne_exp = 1'b0;
`endif
      chk("branch_f3_001", 32'(PCSrcE), 32'(bne_exp));

      // asynchronous reset mid-stream
      step(LW, 3'd2, 7'd0, 1'b0, 1'b0);
      step(JAL, 3'd0, 7'd0, 1'b0, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      exp_e = '0; exp_m = '0; exp_w = '0;
      check_regs();
      chk("midrst_PCSrcE", 32'(PCSrcE), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step(RT, 3'd0, 7'd0, 1'b0, 1'b0);
      chk("post_rst_RegWriteE", 32'(RegWriteE), 32'd1);
      chk("post_rst_RegWriteM", 32'(RegWriteM), 32'd0);

      for (int i = 0; i < 400; i++) begin
         int k;
         k = $urandom_range(0, 6);
         ro = (k == 6) ? 7'($urandom_range(0, 127)) : ops[k];
         k = $urandom_range(0, 2);
         rf7 = (k == 0) ? 7'd0 : ((k == 1) ? 7'h20 : 7'($urandom_range(0, 127)));
         step(ro, 3'($urandom_range(0, 7)), rf7, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
